// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the multicycle CPU control path.
// Holds the opcode constants, the datapath select encodings, the control
// state enumeration, the bundle of control outputs, and the function that
// decodes a state into its control bundle. The FSM in multicycle_control
// imports everything from here.
package cpu_defs_pkg;

    // Opcode field IR[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    // ALU B-operand mux select
    localparam logic [1:0] SRCB_REG  = 2'd0;
    localparam logic [1:0] SRCB_ONE  = 2'd1;
    localparam logic [1:0] SRCB_SEXT = 2'd2;
    localparam logic [1:0] SRCB_ZEXT = 2'd3;

    // ALU operation select
    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;
    localparam logic [1:0] ALUOP_OR    = 2'd3;

    // PC source mux select
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEXEC = 4'd6,
        S_RTWB   = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11,
        S_OREXEC = 4'd12,
        S_HALT   = 4'd15
    } state_t;

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       memtoReg;
        logic       regDst;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic [1:0] pcSource;
    } ctrl_t;

    // Moore output decode: every field not named for a state stays 0.
    function automatic ctrl_t ctrlFor(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.memRead  = 1'b1;
                c.irWrite  = 1'b1;
                c.aluSrcB  = SRCB_ONE;
                c.aluOp    = ALUOP_ADD;
                c.pcSource = PCSRC_ALU;
                c.pcWrite  = 1'b1;
            end
            S_DECODE: begin
                c.aluSrcB = SRCB_SEXT;   // branch target into ALUOut
                c.aluOp   = ALUOP_ADD;
            end
            S_MEMADR: begin
                c.aluSrcA = 1'b1;
                c.aluSrcB = SRCB_SEXT;
                c.aluOp   = ALUOP_ADD;
            end
            S_MEMRD: begin
                c.memRead = 1'b1;
                c.iorD    = 1'b1;
            end
            S_MEMWB: begin
                c.regWrite = 1'b1;
                c.memtoReg = 1'b1;
            end
            S_MEMWR: begin
                c.memWrite = 1'b1;
                c.iorD     = 1'b1;
            end
            S_RTEXEC: begin
                c.aluSrcA = 1'b1;
                c.aluSrcB = SRCB_REG;
                c.aluOp   = ALUOP_FUNCT;
            end
            S_RTWB: begin
                c.regWrite = 1'b1;
                c.regDst   = 1'b1;
            end
            S_BRANCH: begin
                c.aluSrcA     = 1'b1;
                c.aluSrcB     = SRCB_REG;
                c.aluOp       = ALUOP_SUB;
                c.pcWriteCond = 1'b1;
                c.pcSource    = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                c.pcWrite  = 1'b1;
                c.pcSource = PCSRC_JUMP;
            end
            S_IEXEC: begin
                c.aluSrcA = 1'b1;
                c.aluSrcB = SRCB_SEXT;
                c.aluOp   = ALUOP_ADD;
            end
            S_OREXEC: begin
                c.aluSrcA = 1'b1;
                c.aluSrcB = SRCB_ZEXT;
                c.aluOp   = ALUOP_OR;
            end
            S_IWB: begin
                c.regWrite = 1'b1;
            end
            default: c = '0;   // HALT and unreachable codes drive nothing
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle CPU datapath.
// Decodes the opcode held in the instruction register and sequences
// FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, driving every datapath select
// and enable as a Moore function of the current state.
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   Op[5:0]         opcode IR[31:26], looked at in DECODE and MEMADR only
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
//   MemtoReg, RegDst, RegWrite, ALUSrcA      single-bit controls
//   ALUSrcB[1:0], ALUOp[1:0], PCSource[1:0]  mux/operation selects
//   State[3:0]      current state, for debug and verification
// ILLEGAL_TRAP: 1 = unknown opcode halts until reset, 0 = treated as NOP.
module multicycle_control
    import cpu_defs_pkg::*;
#(
    parameter int ILLEGAL_TRAP = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] State
);

    state_t state;
    state_t nextState;
    ctrl_t  ctrlReg;
    ctrl_t  ctrlOut;

    always_comb begin
        nextState = S_FETCH;
        case (state)
            S_FETCH:  nextState = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: nextState = S_MEMADR;
                    OP_RTYPE:     nextState = S_RTEXEC;
                    OP_BEQ:       nextState = S_BRANCH;
                    OP_J:         nextState = S_JUMP;
                    OP_ADDI:      nextState = S_IEXEC;
                    OP_ORI:       nextState = S_OREXEC;
                    default:      nextState = (ILLEGAL_TRAP != 0) ? S_HALT : S_FETCH;
                endcase
            end
            S_MEMADR: nextState = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  nextState = S_MEMWB;
            S_MEMWB:  nextState = S_FETCH;
            S_MEMWR:  nextState = S_FETCH;
            S_RTEXEC: nextState = S_RTWB;
            S_RTWB:   nextState = S_FETCH;
            S_BRANCH: nextState = S_FETCH;
            S_JUMP:   nextState = S_FETCH;
            S_IEXEC:  nextState = S_IWB;
            S_OREXEC: nextState = S_IWB;
            S_IWB:    nextState = S_FETCH;
            S_HALT:   nextState = S_HALT;
            default:  nextState = S_FETCH;   // 13/14 recover to FETCH
        endcase
    end

    // Outputs are registered together with the state: the register holds
    // the decode of the state being entered, so it is a clean Moore output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_FETCH;
            ctrlReg <= ctrlFor(S_FETCH);
        end else begin
            state   <= nextState;
            ctrlReg <= ctrlFor(nextState);
        end
    end

    // While reset is held the datapath must not be disturbed even before
    // the reset edge lands, so the override is combinational: FETCH selects
    // with every write/strobe suppressed.
    always_comb begin
        ctrlOut = ctrlReg;
        if (reset) begin
            ctrlOut             = ctrlFor(S_FETCH);
            ctrlOut.pcWrite     = 1'b0;
            ctrlOut.pcWriteCond = 1'b0;
            ctrlOut.memRead     = 1'b0;
            ctrlOut.memWrite    = 1'b0;
            ctrlOut.irWrite     = 1'b0;
            ctrlOut.regWrite    = 1'b0;
        end
    end

    assign PCWrite     = ctrlOut.pcWrite;
    assign PCWriteCond = ctrlOut.pcWriteCond;
    assign IorD        = ctrlOut.iorD;
    assign MemRead     = ctrlOut.memRead;
    assign MemWrite    = ctrlOut.memWrite;
    assign IRWrite     = ctrlOut.irWrite;
    assign MemtoReg    = ctrlOut.memtoReg;
    assign RegDst      = ctrlOut.regDst;
    assign RegWrite    = ctrlOut.regWrite;
    assign ALUSrcA     = ctrlOut.aluSrcA;
    assign ALUSrcB     = ctrlOut.aluSrcB;
    assign ALUOp       = ctrlOut.aluOp;
    assign PCSource    = ctrlOut.pcSource;
    assign State       = state;

endmodule
